// File: rtl/ym3438_lfo_sched.sv
// ym3438_lfo_sched: host register write buffer and 24-slot scheduler for the LFO/PM path.
// Optional: YM3438_LFO_SCHED_TESTREG_EN adds storage for test register 0x21.
module ym3438_lfo_sched (
    input  logic        MCLK,
    input  logic        IC,
    input  logic        cen,
    input  logic        wr_valid,
    output logic        wr_ready,
    input  logic        wr_bank,
    input  logic [7:0]  wr_addr,
    input  logic [7:0]  wr_data,
    output logic [4:0]  slot,
    output logic        fsm_sel23,
    output logic [3:0]  lfo,
    output logic [7:0]  reg_21,
    output logic [2:0]  pms,
    output logic [10:0] fnum
);
    localparam int SLOTS    = 24;
    localparam int CHANNELS = 6;

    logic        pend;
    logic        p_bank;
    logic [7:0]  p_addr;
    logic [7:0]  p_data;
    logic [2:0]  hi_latch;
    logic [2:0]  ch_pms  [CHANNELS];
    logic [10:0] ch_fnum [CHANNELS];

    logic       accept;
    logic       commit;
    logic [4:0] slot_nx;
    logic [2:0] ch_nx;
    logic [2:0] p_ch;
    logic       do_lfo;
    logic       do_hi;
    logic       do_fnum;
    logic       do_pms;

    assign accept  = wr_valid && wr_ready;
    assign commit  = pend && cen;
    assign slot_nx = (slot == 5'(SLOTS - 1)) ? 5'd0 : slot + 5'd1;
    assign ch_nx   = 3'(slot_nx % 5'(CHANNELS));
    assign p_ch    = (p_bank ? 3'd3 : 3'd0) + {1'b0, p_addr[1:0]};

    // Low address bits of 3 never select a channel, in any register group.
    always_comb begin
        do_lfo  = 1'b0;
        do_hi   = 1'b0;
        do_fnum = 1'b0;
        do_pms  = 1'b0;
        if (commit && p_addr[1:0] != 2'd3) begin
            case (p_addr[7:2])
                6'b001000: do_lfo  = !p_bank && p_addr[1:0] == 2'd2;
                6'b101000: do_fnum = 1'b1;
                6'b101001: do_hi   = 1'b1;
                6'b101101: do_pms  = 1'b1;
                default:   ;
            endcase
        end
    end

    always_ff @(posedge MCLK) begin
        if (IC) begin
            slot      <= 5'd0;
            fsm_sel23 <= 1'b0;
            pms       <= 3'd0;
            fnum      <= 11'd0;
            lfo       <= 4'd0;
            hi_latch  <= 3'd0;
            pend      <= 1'b0;
            wr_ready  <= 1'b0;
            p_bank    <= 1'b0;
            p_addr    <= 8'd0;
            p_data    <= 8'd0;
            for (int i = 0; i < CHANNELS; i++) begin
                ch_pms[i]  <= 3'd0;
                ch_fnum[i] <= 11'd0;
            end
        end else begin
            // Output load reads channel state from before this edge's commit.
            if (cen) begin
                slot      <= slot_nx;
                fsm_sel23 <= (slot_nx == 5'(SLOTS - 1));
                pms       <= ch_pms[ch_nx];
                fnum      <= ch_fnum[ch_nx];
            end
            if (commit) begin
                pend     <= 1'b0;
                wr_ready <= 1'b1;
            end else if (accept) begin
                pend     <= 1'b1;
                wr_ready <= 1'b0;
                p_bank   <= wr_bank;
                p_addr   <= wr_addr;
                p_data   <= wr_data;
            end else begin
                wr_ready <= !pend;
            end
            if (do_lfo)  lfo <= p_data[3:0];
            if (do_hi)   hi_latch <= p_data[2:0];
            if (do_fnum) ch_fnum[p_ch] <= {hi_latch, p_data};
            if (do_pms)  ch_pms[p_ch] <= p_data[2:0];
        end
    end

`ifdef YM3438_LFO_SCHED_TESTREG_EN
    logic do_r21;
    assign do_r21 = commit && !p_bank && p_addr == 8'h21;

    always_ff @(posedge MCLK) begin
        if (IC)          reg_21 <= 8'h00;
        else if (do_r21) reg_21 <= p_data;
    end
`else
    assign reg_21 = 8'h00;
`endif

endmodule

// File: tb/tb_ym3438_lfo_sched.sv
// Testbench for ym3438_lfo_sched: randomized stimulus against a behavioural model.
// Honours YM3438_LFO_SCHED_TESTREG_EN for the expected reg_21 behaviour.
module tb_ym3438_lfo_sched;
    logic        MCLK = 1'b0;
    logic        IC = 1'b1;
    logic        cen = 1'b0;
    logic        wr_valid = 1'b0;
    logic        wr_bank = 1'b0;
    logic [7:0]  wr_addr = 8'h00;
    logic [7:0]  wr_data = 8'h00;
    logic        wr_ready;
    logic [4:0]  slot;
    logic        fsm_sel23;
    logic [3:0]  lfo;
    logic [7:0]  reg_21;
    logic [2:0]  pms;
    logic [10:0] fnum;

    int n_chk = 0;
    int n_fail = 0;

    always #5 MCLK = ~MCLK;

    ym3438_lfo_sched dut (
        .MCLK(MCLK), .IC(IC), .cen(cen),
        .wr_valid(wr_valid), .wr_ready(wr_ready),
        .wr_bank(wr_bank), .wr_addr(wr_addr), .wr_data(wr_data),
        .slot(slot), .fsm_sel23(fsm_sel23), .lfo(lfo),
        .reg_21(reg_21), .pms(pms), .fnum(fnum)
    );

    // Behavioural model: register file and slot position as plain integers.
    int m_slot, m_lfo, m_r21, m_hi, m_opms, m_ofnum;
    int m_pms[6];
    int m_fnum[6];
    bit m_pend, m_alive, m_ready;
    int m_pbank, m_paddr, m_pdata;

    task automatic model_reset();
        m_slot = 0; m_lfo = 0; m_r21 = 0; m_hi = 0;
        m_opms = 0; m_ofnum = 0; m_pend = 0; m_alive = 0;
        for (int i = 0; i < 6; i++) begin m_pms[i] = 0; m_fnum[i] = 0; end
    endtask

    task automatic model_apply();
        int lo, ch;
        lo = m_paddr % 4;
        ch = m_pbank * 3 + lo;
        if (lo != 3) begin
            if (m_paddr == 'h21 && m_pbank == 0) begin
`ifdef YM3438_LFO_SCHED_TESTREG_EN
                m_r21 = m_pdata;
`endif
            end else if (m_paddr == 'h22 && m_pbank == 0)
                m_lfo = m_pdata % 16;
            else if (m_paddr >= 'hA4 && m_paddr <= 'hA6)
                m_hi = m_pdata % 8;
            else if (m_paddr >= 'hA0 && m_paddr <= 'hA2)
                m_fnum[ch] = m_hi * 256 + m_pdata;
            else if (m_paddr >= 'hB4 && m_paddr <= 'hB6)
                m_pms[ch] = m_pdata % 8;
        end
    endtask

    task automatic tick();
        bit acc;
        int nxt;
        @(posedge MCLK);
        if (IC) model_reset();
        else begin
            acc = wr_valid && m_ready;
            if (cen) begin
                nxt = (m_slot + 1) % 24;
                m_opms = m_pms[nxt % 6];
                m_ofnum = m_fnum[nxt % 6];
                m_slot = nxt;
            end
            if (cen && m_pend) begin
                model_apply();
                m_pend = 0;
            end else if (acc) begin
                m_pbank = wr_bank; m_paddr = wr_addr; m_pdata = wr_data;
                m_pend = 1;
            end
            m_alive = 1;
        end
        m_ready = m_alive && !m_pend;
        #1;
    endtask

    task automatic do_write(input int b, input int a, input int d, output bit ok);
        bit acc;
        ok = 0;
        wr_bank = b[0]; wr_addr = a[7:0]; wr_data = d[7:0]; wr_valid = 1;
        for (int i = 0; i < 40; i++) begin
            cen = 1'($urandom % 2);
            acc = (wr_ready === 1'b1);
            tick();
            if (acc) begin ok = 1; break; end
        end
        wr_valid = 0;
        for (int i = 0; i < 40 && m_pend; i++) begin
            cen = 1'($urandom % 2);
            tick();
        end
        if (m_pend) ok = 0;
    endtask

    task automatic test_reset();
        IC = 1; cen = 1; wr_valid = 1; wr_addr = 8'h22; wr_data = 8'h0F;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_chk++;
            if ({slot, fsm_sel23, lfo, reg_21, pms, fnum, wr_ready} !== '0) begin
                n_fail++;
                $display("FAIL reset_outputs: got slot=%0d sel=%b lfo=%h r21=%h pms=%0d fnum=%h rdy=%b expected all 0",
                         slot, fsm_sel23, lfo, reg_21, pms, fnum, wr_ready);
            end
        end
        IC = 0; wr_valid = 0;
        for (int i = 0; i < 30; i++) begin
            tick();
            n_chk++;
            if (slot !== 5'(m_slot) || fsm_sel23 !== (m_slot == 23)) begin
                n_fail++;
                $display("FAIL slot_wrap: got slot=%0d sel=%b expected slot=%0d sel=%b",
                         slot, fsm_sel23, m_slot, m_slot == 23);
            end
            if (i == 0) begin
                n_chk++;
                if (wr_ready !== 1'b1) begin
                    n_fail++;
                    $display("FAIL ready_after_reset: got %b expected 1", wr_ready);
                end
            end
        end
    endtask

    task automatic test_lfo();
        int gap;
        cen = 0; wr_valid = 1; wr_bank = 0; wr_addr = 8'h22; wr_data = 8'h0B;
        tick();
        wr_valid = 0;
        gap = $urandom_range(0, 3);
        for (int i = 0; i <= gap; i++) begin
            n_chk++;
            if (wr_ready !== 1'b0 || lfo !== 4'h0) begin
                n_fail++;
                $display("FAIL lfo_pending: got rdy=%b lfo=%h expected rdy=0 lfo=0", wr_ready, lfo);
            end
            if (i < gap) tick();
        end
        cen = 1;
        tick();
        n_chk++;
        if (lfo !== 4'hB || lfo !== 4'(m_lfo) || wr_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL lfo_commit: got lfo=%h rdy=%b expected lfo=b rdy=1", lfo, wr_ready);
        end
    endtask

    task automatic test_fnum_pair();
        bit ok1, ok2;
        do_write(1, 'hA5, 'h05, ok1);
        do_write(1, 'hA1, 'h3C, ok2);
        n_chk++;
        if (!(ok1 && ok2)) begin
            n_fail++;
            $display("FAIL fnum_write_timeout: got ok=%b%b expected 11", ok1, ok2);
        end
        cen = 1;
        for (int i = 0; i < 6; i++) tick();
        for (int i = 0; i < 24; i++) begin
            tick();
            n_chk++;
            if (fnum !== ((m_slot % 6 == 4) ? 11'h53C : 11'h000) || fnum !== 11'(m_ofnum)) begin
                n_fail++;
                $display("FAIL fnum_pair: slot=%0d got %h expected %h", slot, fnum,
                         (m_slot % 6 == 4) ? 11'h53C : 11'h000);
            end
        end
    endtask

    task automatic test_pms_seq();
        bit ok;
        for (int c = 0; c < 6; c++) begin
            do_write(c / 3, 'hB4 + c % 3, c + 1, ok);
            n_chk++;
            if (!ok) begin
                n_fail++;
                $display("FAIL pms_write_timeout: ch=%0d got 0 expected 1", c);
            end
        end
        cen = 1;
        for (int i = 0; i < 6; i++) tick();
        for (int i = 0; i < 24; i++) begin
            tick();
            n_chk++;
            if (pms !== 3'(m_slot % 6 + 1)) begin
                n_fail++;
                $display("FAIL pms_seq: slot=%0d got %0d expected %0d", slot, pms, m_slot % 6 + 1);
            end
        end
        for (int i = 0; i < 24 && m_slot % 6 != 1; i++) tick();
        cen = 0; wr_valid = 1; wr_bank = 0; wr_addr = 8'hB6; wr_data = 8'h07;
        tick();
        wr_valid = 0; cen = 1;
        tick();
        n_chk++;
        if (m_slot % 6 != 2 || pms !== 3'd3) begin
            n_fail++;
            $display("FAIL pms_same_edge: slot=%0d got %0d expected 3", slot, pms);
        end
        for (int i = 0; i < 6; i++) tick();
        n_chk++;
        if (m_slot % 6 != 2 || pms !== 3'd7) begin
            n_fail++;
            $display("FAIL pms_next_visit: slot=%0d got %0d expected 7", slot, pms);
        end
    endtask

    task automatic test_boundary();
        bit ok1, ok2, ok3;
        logic [7:0] exp21;
        do_write(0, 'hA3, 'h55, ok1);
        do_write(1, 'h22, 'h0F, ok2);
        cen = 1;
        for (int i = 0; i < 24; i++) begin
            tick();
            n_chk++;
            if (!(ok1 && ok2) || lfo !== 4'hB || fnum !== 11'(m_ofnum) || pms !== 3'(m_opms)) begin
                n_fail++;
                $display("FAIL ignored_addr: got lfo=%h fnum=%h pms=%0d expected lfo=b fnum=%h pms=%0d",
                         lfo, fnum, pms, m_ofnum, m_opms);
            end
        end
        do_write(0, 'h21, 'hFF, ok3);
`ifdef YM3438_LFO_SCHED_TESTREG_EN
        exp21 = 8'hFF;
`else
        exp21 = 8'h00;
`endif
        n_chk++;
        if (!ok3 || reg_21 !== exp21) begin
            n_fail++;
            $display("FAIL reg21_write: got %h expected %h", reg_21, exp21);
        end
        cen = 0; wr_valid = 1; wr_bank = 0; wr_addr = 8'h22; wr_data = 8'h03;
        tick();
        wr_valid = 0; IC = 1; cen = 1;
        tick();
        IC = 0;
        for (int i = 0; i < 4; i++) begin
            tick();
            n_chk++;
            if (lfo !== 4'h0 || wr_ready !== 1'b1 || slot !== 5'(m_slot)) begin
                n_fail++;
                $display("FAIL reset_drops_write: got lfo=%h rdy=%b slot=%0d expected lfo=0 rdy=1 slot=%0d",
                         lfo, wr_ready, slot, m_slot);
            end
        end
    endtask

    task automatic test_back_to_back();
        int addrs[14] = '{'h21, 'h22, 'hA0, 'hA1, 'hA2, 'hA3, 'hA4,
                          'hA5, 'hA6, 'hB4, 'hB5, 'hB6, 'hB7, 'h30};
        int bad = 0;
        for (int i = 0; i < 400; i++) begin
            wr_valid = 1'($urandom % 3 != 0);
            wr_bank  = 1'($urandom % 2);
            wr_addr  = 8'(addrs[$urandom % 14]);
            wr_data  = 8'($urandom);
            cen      = 1'($urandom % 4 != 0);
            tick();
            n_chk++;
            if (slot !== 5'(m_slot) || fsm_sel23 !== (m_slot == 23) || lfo !== 4'(m_lfo) ||
                reg_21 !== 8'(m_r21) || pms !== 3'(m_opms) || fnum !== 11'(m_ofnum) ||
                wr_ready !== m_ready) begin
                n_fail++;
                if (bad++ < 10)
                    $display("FAIL random_b2b: cyc=%0d got slot=%0d lfo=%h r21=%h pms=%0d fnum=%h rdy=%b expected slot=%0d lfo=%h r21=%h pms=%0d fnum=%h rdy=%b",
                             i, slot, lfo, reg_21, pms, fnum, wr_ready,
                             m_slot, m_lfo, m_r21, m_opms, m_ofnum, m_ready);
            end
        end
        wr_valid = 0;
    endtask

    initial begin
        model_reset();
        m_ready = 0;
        #1;
        test_reset();
        test_lfo();
        test_fnum_pair();
        test_pms_seq();
        test_boundary();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
